bin_to_bcd_seq: RTL and testbench

- Sequential shift-add-3 ("double dabble") converter: binary operand in, packed BCD digits out.
- Sits directly upstream of the per-digit seven-segment decoders. Each 4-bit BCD nibble drives one decoder's ones input.
- Start/busy/done handshake; result registers are held stable between conversions so displays never flicker.

---
 rtl/bin_to_bcd_seq.sv | 87 ++++++++
 tb/tb_bin_to_bcd_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential double-dabble binary-to-BCD converter; LEADING_ZERO_BLANK_EN adds the blank mask
module bin_to_bcd_seq #(
    parameter int WIDTH = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  overflow
`ifdef LEADING_ZERO_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;
    localparam int CW = $clog2(WIDTH + 1);
    logic [0:0] state;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [4*DIGITS-1:0] scr, adj, scr_nxt;
    logic sticky, carry, ovf_nxt, last;
    logic [CW-1:0] cnt;
    always_comb begin
        adj = scr;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i+:4] = scr[4*i+:4] >= 4'd5 ? scr[4*i+:4] + 4'd3 : scr[4*i+:4];
        {carry, scr_nxt, sr_nxt} = {adj, sr, 1'b0};
        ovf_nxt = sticky | carry;
    end
    assign last = state == SHIFT && cnt == CW'(1);
    assign busy = state == SHIFT;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            done     <= 1'b0;
            sr       <= '0;
            scr      <= '0;
            sticky   <= 1'b0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state  <= SHIFT;
                    sr     <= bin;
                    scr    <= '0;
                    sticky <= 1'b0;
                    cnt    <= CW'(WIDTH);
                end
            end else begin
                sr     <= sr_nxt;
                scr    <= scr_nxt;
                sticky <= ovf_nxt;
                cnt    <= cnt - CW'(1);
                if (last) begin
                    state    <= IDLE;
                    done     <= 1'b1;
                    bcd      <= ovf_nxt ? {DIGITS{4'h9}} : scr_nxt;
                    overflow <= ovf_nxt;
                end
            end
        end
    end
`ifdef LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] blank_nxt;
    logic hz;
    // a digit blanks only if it and every digit above it is zero; ones always shows
    always_comb begin
        hz = 1'b1;
        blank_nxt = '0;
        for (int i = DIGITS - 1; i > 0; i--) begin
            hz = hz & (scr_nxt[4*i+:4] == 4'd0);
            blank_nxt[i] = hz & ~ovf_nxt;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) blank <= ~DIGITS'(1);
        else if (last) blank <= blank_nxt;
    end
`endif
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: scoreboard bench for bin_to_bcd_seq (DIGITS=3 and DIGITS=2 instances)
module tb_bin_to_bcd_seq;
    logic clk = 0, rst_n = 0, start = 0, start2 = 0;
    logic [7:0] bin = 0, bin2 = 0;
    logic busy, done, overflow, busy2, done2, overflow2;
    logic [11:0] bcd;
    logic [7:0] bcd2;
`ifdef LEADING_ZERO_BLANK_EN
    logic [2:0] blank;
    logic [1:0] blank2;
`endif
    int compared = 0, mismatched = 0, cyc = 0;
    typedef struct {logic [11:0] bcd; logic ovf; logic [2:0] blk; int acc;} exp_t;
    exp_t q[$], q2[$];
    exp_t e1, e2;
    logic [11:0] hold = 0;
    logic [7:0] hold2 = 0;
    logic hold_ovf = 0, hold_ovf2 = 0;
    logic [2:0] hold_blk = 3'b110;
    logic [1:0] hold_blk2 = 2'b10;

    bin_to_bcd_seq dut (.clk(clk), .rst_n(rst_n), .start(start), .bin(bin), .busy(busy),
        .done(done), .bcd(bcd), .overflow(overflow)
`ifdef LEADING_ZERO_BLANK_EN
        , .blank(blank)
`endif
    );
    bin_to_bcd_seq #(.WIDTH(8), .DIGITS(2)) dut2 (.clk(clk), .rst_n(rst_n), .start(start2),
        .bin(bin2), .busy(busy2), .done(done2), .bcd(bcd2), .overflow(overflow2)
`ifdef LEADING_ZERO_BLANK_EN
        , .blank(blank2)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference: plain decimal arithmetic, saturating to all nines beyond 10^d-1
    function automatic exp_t model(int v, int d, int acc);
        exp_t e;
        int p = 1;
        e.bcd = '0;
        e.blk = '0;
        e.acc = acc;
        for (int i = 0; i < d; i++) p *= 10;
        e.ovf = v >= p;
        for (int i = 0; i < d; i++) e.bcd[4*i+:4] = e.ovf ? 4'd9 : 4'((v / 10**i) % 10);
        for (int i = 1; i < d; i++) e.blk[i] = !e.ovf && v < 10**i;
        return e;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", n, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            hold = 0;
            hold_ovf = 0;
            hold_blk = 3'b110;
        end else begin
            if (done) begin
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    e1 = q.pop_front();
                    chk("latency", cyc - e1.acc, 8);
                    hold = e1.bcd;
                    hold_ovf = e1.ovf;
                    hold_blk = e1.blk;
                end
            end
            chk("bcd", bcd, hold);
            chk("overflow", overflow, hold_ovf);
`ifdef LEADING_ZERO_BLANK_EN
            chk("blank", blank, hold_blk);
`endif
            chk("busy", busy, q.size() > 0 && cyc >= q[0].acc && cyc < q[0].acc + 8);
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            q2.delete();
            hold2 = 0;
            hold_ovf2 = 0;
            hold_blk2 = 2'b10;
        end else begin
            if (done2) begin
                if (q2.size() == 0) chk("spurious_done2", 1, 0);
                else begin
                    e2 = q2.pop_front();
                    chk("latency2", cyc - e2.acc, 8);
                    hold2 = e2.bcd[7:0];
                    hold_ovf2 = e2.ovf;
                    hold_blk2 = e2.blk[1:0];
                end
            end
            chk("bcd2", bcd2, hold2);
            chk("overflow2", overflow2, hold_ovf2);
`ifdef LEADING_ZERO_BLANK_EN
            chk("blank2", blank2, hold_blk2);
`endif
            chk("busy2", busy2, q2.size() > 0 && cyc >= q2[0].acc && cyc < q2[0].acc + 8);
        end
    end

    task automatic convert(int v, bit two);
        if (two) begin
            start2 = 1;
            bin2 = 8'(v);
            q2.push_back(model(v, 2, cyc + 1));
        end else begin
            start = 1;
            bin = 8'(v);
            q.push_back(model(v, 3, cyc + 1));
        end
        @(negedge clk);
        start = 0;
        start2 = 0;
    endtask

    task automatic wait_idle(bit two);
        for (int i = 0; i < 40 && (two ? q2.size() : q.size()) > 0; i++) @(negedge clk);
        if ((two ? q2.size() : q.size()) > 0) begin
            chk("done_timeout", 1, 0);
            if (two) q2.delete(); else q.delete();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_bcd", bcd, 0);
        chk("rst_ovf", overflow, 0);
        rst_n = 1;
        repeat (20) @(negedge clk);
        convert(255, 0); wait_idle(0);
        convert(0, 0); wait_idle(0);
        convert(99, 0);
        repeat (2) @(negedge clk);
        start = 1; bin = 8'd42;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 20 && !done; i++) @(negedge clk);
        convert(42, 0); wait_idle(0);
        convert(150, 1); wait_idle(1);
        convert(57, 1); wait_idle(1);
        for (int i = 0; i < 6; i++) begin convert($urandom_range(255), 1); wait_idle(1); end
        convert(7, 0); wait_idle(0);
        convert(0, 0); wait_idle(0);
        convert(40, 0); wait_idle(0);
        convert(105, 0); wait_idle(0);
        for (int i = 0; i < 40; i++) begin
            convert($urandom_range(255), 0);
            if ($urandom_range(1) == 1) begin
                repeat ($urandom_range(6)) @(negedge clk);
                start = 1; bin = 8'($urandom);
                @(negedge clk);
                start = 0;
            end
            wait_idle(0);
            repeat ($urandom_range(2)) @(negedge clk);
        end
        convert(17, 0); wait_idle(0);
        convert(200, 0);
        repeat (4) @(posedge clk);
        #1 rst_n = 0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_bcd", bcd, 0);
        chk("abort_done", done, 0);
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (12) @(negedge clk);
        convert(200, 0); wait_idle(0);
        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
